// File: rtl/rr_sched_pkg.sv
// Shared request-field layout helpers and constant functions for the round-robin
// scheduling kernel.
package rr_sched_pkg;

  localparam int unsigned DATA_LSB = 0;

  function automatic int unsigned req_width(input int unsigned addr_w, input int unsigned value_w);
    return addr_w + value_w + 1;
  endfunction

  function automatic int unsigned valid_bit(input int unsigned req_w);
    return req_w - 1;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned value_w);
    return value_w;
  endfunction

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_bank_arbiter.sv
// Per-bank round-robin arbiter granting up to NPORTS candidates per cycle,
// scanning from its own rotating pointer.
module rr_bank_arbiter
  import rr_sched_pkg::*;
#(
  parameter int unsigned NCONSUMERS = 2,
  parameter int unsigned NPORTS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCONSUMERS-1:0] cand,
  output logic [NCONSUMERS-1:0] grant
);

  localparam int unsigned PW = (clog2(NCONSUMERS) > 0) ? clog2(NCONSUMERS) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  int unsigned   scan;
  int unsigned   cnt;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    cnt   = 0;
    scan  = 0;
    idx   = '0;
    for (int unsigned k = 0; k < NCONSUMERS; k++) begin
      scan = 32'(ptr_q) + k;
      if (scan >= NCONSUMERS) scan = scan - NCONSUMERS;
      idx = PW'(scan);
      if (cand[idx] && (cnt < NPORTS)) begin
        grant[idx] = 1'b1;
        cnt        = cnt + 1;
        // Pointer lands just past the most recent grant in scan order.
        ptr_d      = PW'((scan + 1) % NCONSUMERS);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rr_scheduling_kernel.sv
// Banked round-robin scheduler: steers request lanes to banks by address and
// accumulates the data of every granted request into a wrapping counter.
module rr_scheduling_kernel
  import rr_sched_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned VALUE_WIDTH = 8,
  parameter int unsigned NCONSUMERS  = 2,
  parameter int unsigned NBANKS      = 1,
  parameter int unsigned NPORTS      = 1,
  localparam int unsigned REQ_WIDTH  = req_width(ADDR_WIDTH, VALUE_WIDTH)
) (
  output logic [WIDTH-1:0]     value,
  input  logic [REQ_WIDTH-1:0] requests [NCONSUMERS],
  input  logic                 clk,
  input  logic                 reset
);

  localparam int unsigned VALID_BIT = valid_bit(REQ_WIDTH);
  localparam int unsigned ADDR_LSB  = addr_lsb(VALUE_WIDTH);

  logic [NCONSUMERS-1:0] cand  [NBANKS];
  logic [NCONSUMERS-1:0] grant [NBANKS];
  logic [NCONSUMERS-1:0] grant_any;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [WIDTH-1:0]      sum;
  logic [WIDTH-1:0]      value_q;

  // Bank = low address bits; modulo keeps the NBANKS==1 case trivially bank 0.
  always_comb begin
    addr_c = '0;
    for (int unsigned b = 0; b < NBANKS; b++) cand[b] = '0;
    for (int unsigned c = 0; c < NCONSUMERS; c++) begin
      addr_c = requests[c][VALID_BIT-1:ADDR_LSB];
      for (int unsigned b = 0; b < NBANKS; b++) begin
        cand[b][c] = requests[c][VALID_BIT] && ((32'(addr_c) % NBANKS) == b);
      end
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    rr_bank_arbiter #(
      .NCONSUMERS(NCONSUMERS),
      .NPORTS    (NPORTS)
    ) u_arb (
      .clk  (clk),
      .reset(reset),
      .cand (cand[b]),
      .grant(grant[b])
    );
  end

  // Grants only ever select valid lanes, so data of invalid lanes never enters the sum.
  always_comb begin
    grant_any = '0;
    sum       = '0;
    for (int unsigned b = 0; b < NBANKS; b++) grant_any = grant_any | grant[b];
    for (int unsigned c = 0; c < NCONSUMERS; c++) begin
      if (grant_any[c]) sum = sum + WIDTH'(requests[c][VALUE_WIDTH-1:DATA_LSB]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) value_q <= '0;
    else        value_q <= value_q + sum;
  end

  assign value = value_q;

endmodule

// File: tb/tb_rr_scheduling_kernel.sv
// Bench for rr_scheduling_kernel: three configurations checked every cycle
// against a queue-based reference model, plus literal expectations.
module tb_rr_scheduling_kernel;

  typedef struct packed {
    int         p0;
    int         p1;
    logic [7:0] v;
  } mstate_t;

  logic        clk;
  logic        rst;
  logic [12:0] rq0 [2];
  logic [12:0] rq1 [2];
  logic [12:0] rq2 [2];
  logic [7:0]  val0, val1, val2;
  mstate_t     ms0, ms1, ms2;

  int total;
  int bad;
  bit chk_en;
  bit lit_valid;
  int lit_exp [3];
  string lit_name;

  rr_scheduling_kernel u_dut0 (
    .value(val0), .requests(rq0), .clk(clk), .reset(rst)
  );

  rr_scheduling_kernel #(.NBANKS(2), .NPORTS(1)) u_dut1 (
    .value(val1), .requests(rq1), .clk(clk), .reset(rst)
  );

  rr_scheduling_kernel #(.NBANKS(1), .NPORTS(2)) u_dut2 (
    .value(val2), .requests(rq2), .clk(clk), .reset(rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: per bank, list valid same-bank consumers in order starting at the
  // pointer, grant the first np of them, add their data, move pointer past the last.
  function automatic mstate_t step(input logic [12:0] rq [2], input int nb, input int np,
                                   input mstate_t s);
    mstate_t n;
    int      q[$];
    int      ptr;
    int      c;
    n = s;
    for (int b = 0; b < nb; b++) begin
      ptr = (b == 0) ? s.p0 : s.p1;
      q.delete();
      for (int k = 0; k < 2; k++) begin
        c = (ptr + k) % 2;
        if (rq[c][12] === 1'b1) begin
          if ((int'(rq[c][11:8]) % nb) == b) q.push_back(c);
        end
      end
      for (int i = 0; i < q.size() && i < np; i++) begin
        n.v = n.v + rq[q[i]][7:0];
        if (b == 0) n.p0 = (q[i] + 1) % 2;
        else        n.p1 = (q[i] + 1) % 2;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ms0 <= '0;
      ms1 <= '0;
      ms2 <= '0;
    end else begin
      ms0 <= step(rq0, 1, 1, ms0);
      ms1 <= step(rq1, 2, 1, ms1);
      ms2 <= step(rq2, 1, 2, ms2);
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model0", val0, ms0.v);
      check("model1", val1, ms1.v);
      check("model2", val2, ms2.v);
      if (lit_valid) begin
        if (lit_exp[0] >= 0) check({lit_name, "_dut0"}, val0, 8'(lit_exp[0]));
        if (lit_exp[1] >= 0) check({lit_name, "_dut1"}, val1, 8'(lit_exp[1]));
        if (lit_exp[2] >= 0) check({lit_name, "_dut2"}, val2, 8'(lit_exp[2]));
      end
    end
  end

  // Expectation for the next falling edge; -1 skips that instance.
  task automatic expect3(input string name, input int e0, input int e1, input int e2);
    lit_name   = name;
    lit_exp[0] = e0;
    lit_exp[1] = e1;
    lit_exp[2] = e2;
    lit_valid  = 1'b1;
    @(negedge clk);
    #1;
    lit_valid = 1'b0;
  endtask

  task automatic clear_reqs();
    rq0[0] = '0; rq0[1] = '0;
    rq1[0] = '0; rq1[1] = '0;
    rq2[0] = '0; rq2[1] = '0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #11;
    rst = 1'b1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    chk_en    = 1'b0;
    lit_valid = 1'b0;
    lit_name  = "";
    for (int i = 0; i < 3; i++) lit_exp[i] = -1;
    clear_reqs();
    rst = 1'b0;
    #1 chk_en = 1'b1;
    #10 rst = 1'b1;

    // Idle across two resets.
    expect3("idle_a", 0, 0, 0);
    expect3("idle_b", 0, 0, 0);
    reset_pulse();
    expect3("idle_c", 0, 0, 0);
    expect3("idle_d", 0, 0, 0);

    // Single held requester; invalid lane carries X. Bank-split and dual-port configs.
    reset_pulse();
    @(negedge clk); #2;
    rq0[0] = {1'b1, 4'h0, 8'h03};
    rq0[1] = {1'b0, 4'hx, 8'hxx};
    rq1[0] = {1'b1, 4'h0, 8'h01};
    rq1[1] = {1'b1, 4'h1, 8'h02};
    rq2[0] = {1'b1, 4'h0, 8'h01};
    rq2[1] = {1'b1, 4'h1, 8'h02};
    expect3("hold1", 3, 3, 3);
    expect3("hold2", 6, 6, 6);
    expect3("hold3", 9, 9, 9);
    clear_reqs();
    expect3("noreq", 9, 9, 9);

    // Two competing lanes alternate; mid-run reset restarts from consumer 0.
    reset_pulse();
    @(negedge clk); #2;
    rq0[0] = {1'b1, 4'h0, 8'h01};
    rq0[1] = {1'b1, 4'h0, 8'h02};
    expect3("alt1", 1, 0, 0);
    expect3("alt2", 3, 0, 0);
    expect3("alt3", 4, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    expect3("midrst", 0, 0, 0);
    #1 rst = 1'b1;
    expect3("post1", 1, 0, 0);
    expect3("post2", 3, 0, 0);
    expect3("post3", 4, 0, 0);
    clear_reqs();

    // Wrap-around.
    reset_pulse();
    @(negedge clk); #2;
    rq0[0] = {1'b1, 4'h5, 8'hFF};
    expect3("wrap1", 8'hFF, 0, 0);
    expect3("wrap2", 8'hFE, 0, 0);
    expect3("wrap3", 8'hFD, 0, 0);
    clear_reqs();
    expect3("wrap_hold", 8'hFD, 0, 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
